// File: rtl/norm_shift_seq_if.sv
// Handshake bundle between the significand adder, the normalizer and the rounder.
// The slave modport is the normalizer's view and the master modport is the
// upstream/downstream environment's view.
interface norm_shift_seq_if #(
    parameter int SUM_WIDTH = 48,
    parameter int OUT_WIDTH = 24,
    parameter int LZC_WIDTH = 6,
    parameter int EXP_WIDTH = 10
);
    logic                 in_valid;
    logic                 in_ready;
    logic [SUM_WIDTH-1:0] sum_in;
    logic                 sticky_in;
    logic [EXP_WIDTH-1:0] exp_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] mant_out;
    logic                 round_out;
    logic                 sticky_out;
    logic [EXP_WIDTH:0]   exp_out;
    logic [LZC_WIDTH-1:0] lzc_out;
    logic                 zero_out;
    logic                 uf_out;

    modport master (
        output in_valid, sum_in, sticky_in, exp_in, out_ready,
        input  in_ready, out_valid, mant_out, round_out, sticky_out,
               exp_out, lzc_out, zero_out, uf_out
    );

    modport slave (
        input  in_valid, sum_in, sticky_in, exp_in, out_ready,
        output in_ready, out_valid, mant_out, round_out, sticky_out,
               exp_out, lzc_out, zero_out, uf_out
    );
endinterface

// File: rtl/norm_shift_seq.sv
// Iterative post-addition normalizer: shifts the adder magnitude left in coarse
// STEP-bit strides, finishes with one fine shift, then presents the normalized
// significand with round/sticky bits, the corrected exponent and the shift count.
module norm_shift_seq #(
    parameter int SUM_WIDTH = 48,
    parameter int OUT_WIDTH = 24,
    parameter int STEP      = 8,
    parameter int LZC_WIDTH = 6,
    parameter int EXP_WIDTH = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    norm_shift_seq_if.slave bus
);

    localparam int LOW_WIDTH = SUM_WIDTH - OUT_WIDTH - 1;
    localparam int EW1       = EXP_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COARSE = 2'd1,
        FINE   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Leading zeros of a STEP-bit window; the caller guarantees a set bit.
    function automatic logic [LZC_WIDTH-1:0] lead_zeros(input logic [STEP-1:0] v);
        logic [LZC_WIDTH-1:0] n;
        logic                 found;
        n     = '0;
        found = 1'b0;
        for (int i = STEP - 1; i >= 0; i--) begin
            if (found) begin
                n = n;
            end else if (v[i]) begin
                found = 1'b1;
            end else begin
                n = n + LZC_WIDTH'(1);
            end
        end
        return n;
    endfunction

    state_t               state_q, state_d;
    logic [SUM_WIDTH-1:0] sum_q, sum_d;
    logic [LZC_WIDTH-1:0] lzc_q, lzc_d;
    logic                 sticky_q, sticky_d;
    logic [EXP_WIDTH-1:0] exp_q, exp_d;

    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0] mant_q, mant_d;
    logic                 round_q, round_d;
    logic                 sticky_out_q, sticky_out_d;
    logic [EW1-1:0]       exp_out_q, exp_out_d;
    logic [LZC_WIDTH-1:0] lzc_out_q, lzc_out_d;
    logic                 zero_q, zero_d;
    logic                 uf_q, uf_d;

    logic [SUM_WIDTH-1:0] shifted_s;
    logic [LZC_WIDTH-1:0] fine_p_s;
    logic [EW1-1:0]       exp_diff_s;

    // Next-state, datapath and result computation for the normalizer FSM.
    always_comb begin
        state_d      = state_q;
        sum_d        = sum_q;
        lzc_d        = lzc_q;
        sticky_d     = sticky_q;
        exp_d        = exp_q;
        mant_d       = mant_q;
        round_d      = round_q;
        sticky_out_d = sticky_out_q;
        exp_out_d    = exp_out_q;
        lzc_out_d    = lzc_out_q;
        zero_d       = zero_q;
        uf_d         = uf_q;
        shifted_s    = '0;
        fine_p_s     = '0;
        exp_diff_s   = '0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sum_d    = bus.sum_in;
                    sticky_d = bus.sticky_in;
                    exp_d    = bus.exp_in;
                    lzc_d    = '0;
                    state_d  = COARSE;
                end else begin
                    state_d  = IDLE;
                end
            end
            COARSE: begin
                if (sum_q == '0) begin
                    // All-zero magnitude: report full-width shift, exponent untouched.
                    lzc_d        = LZC_WIDTH'(SUM_WIDTH);
                    mant_d       = '0;
                    round_d      = 1'b0;
                    sticky_out_d = sticky_q;
                    exp_out_d    = {1'b0, exp_q};
                    lzc_out_d    = LZC_WIDTH'(SUM_WIDTH);
                    zero_d       = 1'b1;
                    uf_d         = 1'b0;
                    state_d      = DONE;
                end else if (sum_q[SUM_WIDTH-1 -: STEP] == '0) begin
                    sum_d   = sum_q << STEP;
                    lzc_d   = lzc_q + LZC_WIDTH'(STEP);
                    state_d = COARSE;
                end else begin
                    state_d = FINE;
                end
            end
            FINE: begin
                fine_p_s     = lead_zeros(sum_q[SUM_WIDTH-1 -: STEP]);
                shifted_s    = sum_q << fine_p_s;
                sum_d        = shifted_s;
                lzc_d        = lzc_q + fine_p_s;
                exp_diff_s   = {1'b0, exp_q} - EW1'(lzc_d);
                mant_d       = shifted_s[SUM_WIDTH-1 -: OUT_WIDTH];
                round_d      = shifted_s[LOW_WIDTH];
                sticky_out_d = (|shifted_s[LOW_WIDTH-1:0]) | sticky_q;
                exp_out_d    = exp_diff_s;
                lzc_out_d    = lzc_d;
                zero_d       = 1'b0;
                // Underflow when the signed exponent is zero or negative.
                uf_d         = exp_diff_s[EW1-1] | (exp_diff_s == '0);
                state_d      = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State, working registers and registered outputs with async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sum_q        <= '0;
            lzc_q        <= '0;
            sticky_q     <= 1'b0;
            exp_q        <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            mant_q       <= '0;
            round_q      <= 1'b0;
            sticky_out_q <= 1'b0;
            exp_out_q    <= '0;
            lzc_out_q    <= '0;
            zero_q       <= 1'b0;
            uf_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            sum_q        <= sum_d;
            lzc_q        <= lzc_d;
            sticky_q     <= sticky_d;
            exp_q        <= exp_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            mant_q       <= mant_d;
            round_q      <= round_d;
            sticky_out_q <= sticky_out_d;
            exp_out_q    <= exp_out_d;
            lzc_out_q    <= lzc_out_d;
            zero_q       <= zero_d;
            uf_q         <= uf_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.mant_out   = mant_q;
    assign bus.round_out  = round_q;
    assign bus.sticky_out = sticky_out_q;
    assign bus.exp_out    = exp_out_q;
    assign bus.lzc_out    = lzc_out_q;
    assign bus.zero_out   = zero_q;
    assign bus.uf_out     = uf_q;

endmodule

// File: tb/tb_norm_shift_seq.sv
// Scoreboard bench for norm_shift_seq: a driver pushes reference results into a
// queue at each accepted input; a monitor compares every presented output.
module tb_norm_shift_seq;

    logic clk;
    logic rst_n;

    norm_shift_seq_if #(.SUM_WIDTH(48), .OUT_WIDTH(24), .LZC_WIDTH(6), .EXP_WIDTH(10)) bus ();

    norm_shift_seq #(
        .SUM_WIDTH(48), .OUT_WIDTH(24), .STEP(8), .LZC_WIDTH(6), .EXP_WIDTH(10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [23:0] mant;
        logic        rnd;
        logic        stk;
        logic [10:0] expo;
        logic [5:0]  lzc;
        logic        zero;
        logic        uf;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   edge_cnt = 0;
    bit   seen = 0;
    bit   check_ready_next = 0;
    bit   hold_low = 0;
    int   hold_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: normalize by locating the top set bit with plain arithmetic.
    function automatic exp_t model(input logic [47:0] s, input logic st, input logic [9:0] e);
        exp_t r;
        int   l;
        int   ex;
        logic [47:0] n;
        l = 48;
        for (int i = 47; i >= 0; i--) begin
            if (s[i]) begin
                l = 47 - i;
                break;
            end
        end
        r.acc = 0;
        if (l == 48) begin
            r.mant = 24'h0; r.rnd = 1'b0; r.stk = st;
            r.expo = {1'b0, e}; r.lzc = 6'd48; r.zero = 1'b1; r.uf = 1'b0; r.lat = 1;
        end else begin
            n = s << l;
            ex = int'(e) - l;
            r.mant = n[47:24];
            r.rnd  = n[23];
            r.stk  = (n[22:0] != 23'h0) || st;
            r.expo = 11'(ex);
            r.lzc  = 6'(l);
            r.zero = 1'b0;
            r.uf   = (ex < 1);
            r.lat  = l / 8 + 2;
        end
        return r;
    endfunction

    task automatic send(input logic [47:0] s, input logic st, input logic [9:0] e);
        exp_t x;
        bit   ok;
        x  = model(s, st, e);
        ok = 0;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.sum_in    = s;
        bus.sticky_in = st;
        bus.exp_in    = e;
        for (int w = 0; w < 300; w++) begin
            ok = bus.in_ready;
            @(posedge clk);
            if (ok) break;
            @(negedge clk);
        end
        #1;
        bus.in_valid = 1'b0;
        if (ok) begin
            x.acc = edge_cnt;
            sb_q.push_back(x);
        end else begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready never seen, sum=%h", s);
        end
    endtask

    task automatic wait_drain(input int budget);
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < budget) begin
            @(posedge clk);
            w++;
        end
        chk("drain_pending", sb_q.size(), 0);
    endtask

    // Downstream ready: random, or held low for five valid cycles on request.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_low) begin
                bus.out_ready = 1'b0;
                if (bus.out_valid) begin
                    hold_cnt++;
                    if (hold_cnt >= 5) hold_low = 0;
                end
            end else begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: compare presented outputs against the queue front every cycle.
    always @(negedge clk) begin
        exp_t x;
        if (rst_n && check_ready_next) begin
            chk("in_ready_after_xfer", bus.in_ready, 1);
            check_ready_next = 0;
        end
        if (rst_n && bus.out_valid) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: out_valid with empty scoreboard, mant=%h", bus.mant_out);
            end else begin
                x = sb_q[0];
                if (!seen) begin
                    chk("latency", edge_cnt - x.acc, x.lat);
                    seen = 1;
                end
                chk("mant_out",   bus.mant_out,   x.mant);
                chk("round_out",  bus.round_out,  x.rnd);
                chk("sticky_out", bus.sticky_out, x.stk);
                chk("exp_out",    bus.exp_out,    x.expo);
                chk("lzc_out",    bus.lzc_out,    x.lzc);
                chk("zero_out",   bus.zero_out,   x.zero);
                chk("uf_out",     bus.uf_out,     x.uf);
                chk("in_ready_busy", bus.in_ready, 0);
                if (bus.out_ready) begin
                    void'(sb_q.pop_front());
                    seen = 0;
                    check_ready_next = 1;
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"},  bus.out_valid, 0);
        chk({tag, "_in_ready"},   bus.in_ready, 1);
        chk({tag, "_mant"},       bus.mant_out, 0);
        chk({tag, "_round"},      bus.round_out, 0);
        chk({tag, "_sticky"},     bus.sticky_out, 0);
        chk({tag, "_exp"},        bus.exp_out, 0);
        chk({tag, "_lzc"},        bus.lzc_out, 0);
        chk({tag, "_zero"},       bus.zero_out, 0);
        chk({tag, "_uf"},         bus.uf_out, 0);
    endtask

    initial begin
        logic [47:0] s;
        logic [63:0] r;
        int          l;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.sum_in    = '0;
        bus.sticky_in = 1'b0;
        bus.exp_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases; the first result is stalled five cycles while the
        // second input is already being offered.
        hold_cnt = 0;
        hold_low = 1;
        send(48'h800000000000, 1'b0, 10'd100);
        send(48'h000001800001, 1'b1, 10'd100);
        send(48'h000000000000, 1'b1, 10'd5);
        send(48'h000000000001, 1'b0, 10'd20);
        wait_drain(500);

        // Reset while the lzc=23 case is still shifting.
        send(48'h000001800001, 1'b1, 10'd100);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midop_reset");
        sb_q.delete();
        seen = 0;
        check_ready_next = 0;
        @(negedge clk);
        rst_n = 1'b1;
        send(48'h000001800001, 1'b1, 10'd100);
        wait_drain(500);

        // Randomized traffic across all leading-zero counts.
        for (int t = 0; t < 150; t++) begin
            l = $urandom_range(0, 48);
            r = {$urandom, $urandom};
            if (l == 48) s = 48'h0;
            else s = (r[47:0] >> l) | (48'h1 << (47 - l));
            send(s, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)));
        end
        wait_drain(1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/norm_shift_seq.md
Name: norm_shift_seq

Overview:
Iterative post-addition normalizer for the R4 BFFMA datapath. It left-shifts the wide adder result until its MSB is 1, counts the leading zeros, corrects the exponent, and compacts the discarded low bits into round and sticky bits. It is the left-shift counterpart of the addend right-shift alignment stage. It sits between the significand adder and the rounder, with valid/ready handshakes on both sides.

Parameters:
SUM_WIDTH, 48, width of adder result (must be multiple of STEP, > OUT_WIDTH+1)
OUT_WIDTH, 24, normalized significand width (CSIG_WIDTH+1)
STEP, 8, coarse shift per cycle (power of 2, divides SUM_WIDTH)
LZC_WIDTH, 6, leading-zero count width (holds SUM_WIDTH)
EXP_WIDTH, 10, unsigned exponent input width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input transfer request
in_ready  out  1  block can accept input
sum_in  in  SUM_WIDTH  unsigned magnitude from adder
sticky_in  in  1  sticky from alignment stage
exp_in  in  EXP_WIDTH  pre-normalization exponent
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
mant_out  out  OUT_WIDTH  normalized significand, MSB = 1 unless zero_out
round_out  out  1  first bit below mant_out
sticky_out  out  1  OR of all lower discarded bits, ORed with sticky_in
exp_out  out  EXP_WIDTH+1  signed, exp_in - lzc
lzc_out  out  LZC_WIDTH  total left shift applied
zero_out  out  1  sum_in was all zeros
uf_out  out  1  exp_out < 1 (signed)

Behaviour:
- Reset (rst_n=0, async): state IDLE; in_ready=1. out_valid, mant_out, round_out, sticky_out, exp_out, lzc_out, zero_out, uf_out all 0. Internal sum/lzc registers cleared.
- Reset mid-operation aborts the operation with no output. The first accept after reset release starts clean.
- FSM states: IDLE, COARSE, FINE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge: latch sum_in, sticky_in, exp_in; lzc=0; go to COARSE.
- COARSE, one evaluation per edge:
  - If sum_r == 0: zero_out=1, lzc=SUM_WIDTH, go to DONE.
  - Else if top STEP bits == 0: sum_r <<= STEP, lzc += STEP, stay in COARSE.
  - Else go to FINE.
- FINE, single cycle:
  - p = leading zeros of top STEP bits (0..STEP-1).
  - sum_r <<= p, lzc += p, go to DONE.
- DONE outputs:
  - mant_out = sum_r[SUM_WIDTH-1 -: OUT_WIDTH].
  - round_out = next bit below mant_out.
  - sticky_out = |(remaining lower bits) | sticky_in.
  - exp_out = exp_in - lzc, sign-extended.
  - uf_out = (exp_out <= 0).
  - Zero result: mant_out=0, round_out=0, sticky_out=sticky_in, exp_out=exp_in, uf_out=0.
- Output handshake:
  - out_valid=1 only in DONE; all outputs stay stable while out_valid & !out_ready.
  - On out_ready at an edge: go to IDLE and drop out_valid.
- in_ready=0 in every state except IDLE. There is no overlap; the next accept is earliest one cycle after the output transfer.
- Latency, counted from the accepting edge, with L = leading-zero count and k = floor(L/STEP):
  - Nonzero input: out_valid is high after k+2 edges.
  - Zero input: out_valid is high after 1 edge.
- Outputs are registered; no combinational path from the inputs to any output.

Test Plan:
- Reset released; sum_in=48'h800000000000, exp_in=100, sticky_in=0 -> out_valid after 2 edges; mant_out=24'h800000, round_out=0, sticky_out=0, lzc_out=0, exp_out=100.
- sum_in=48'h000001800001, exp_in=100, sticky_in=1 -> out_valid after 4 edges; mant_out=24'hC00000, round_out=1, sticky_out=1, lzc_out=23, exp_out=77, uf_out=0.
- sum_in=0, sticky_in=1, exp_in=5 -> out_valid after 1 edge; zero_out=1, lzc_out=48, mant_out=0, sticky_out=1, exp_out=5.
- sum_in=48'h000000000001, exp_in=20 -> lzc_out=47, mant_out=24'h800000, exp_out=-27, uf_out=1, out_valid after 7 edges.
- Hold out_ready=0 for 5 cycles in DONE -> outputs frozen; in_ready=0 and in_valid ignored; on release the result transfers and in_ready=1 on the next cycle.
- Assert rst_n=0 during COARSE of the lzc=23 case -> all outputs 0 immediately; a new input after release produces a correct, unaffected result.
